// File: rtl/v_div_pkg.sv
// v_div_pkg: shared constants and state type for the SIMD integer divider.
// funct6 codes, element-width encoding and the divider FSM state enum.
package v_div_pkg;

  localparam logic [5:0] VDIVU = 6'b100000;
  localparam logic [5:0] VDIV  = 6'b100001;
  localparam logic [5:0] VREMU = 6'b100010;
  localparam logic [5:0] VREM  = 6'b100011;

  localparam logic [1:0] SEW_8   = 2'b00;
  localparam logic [1:0] SEW_16  = 2'b01;
  localparam logic [1:0] SEW_32  = 2'b10;
  localparam logic [1:0] SEW_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV    = 2'd1,
    FINISH = 2'd2
  } v_div_state_e;

  // Element width in bits for a sew code (illegal code maps to 8, never used).
  function automatic logic [5:0] sew_bits(input logic [1:0] s);
    case (s)
      SEW_16:  sew_bits = 6'd16;
      SEW_32:  sew_bits = 6'd32;
      default: sew_bits = 6'd8;
    endcase
  endfunction

endpackage

// File: rtl/v_div_lane.sv
// v_div_lane: one restoring-division lane of up to W bits with a runtime
// element width (i_w <= W). Latches magnitudes and sign/special flags on
// i_load, performs one shift-subtract step per i_step, and presents the
// sign-corrected result combinationally. Remainder output exists only when
// V_DIV_REM_EN is defined.
module v_div_lane
  import v_div_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic         i_signed,
  input  logic [5:0]   i_w,
`ifdef V_DIV_REM_EN
  input  logic         i_rem,
`endif
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_res
);

  localparam logic [5:0] W6 = 6'(W);

  logic [W-1:0] w_mask, w_msb, w_a, w_b, w_abs_a, w_abs_b;
  logic         w_a_neg, w_b_neg, w_dz, w_ovf;
  logic [W:0]   w_rem_sh;
  logic [W+1:0] w_diff;
  logic         w_nb;
  logic [W-1:0] w_qmag, w_quo;

  logic [W-1:0] r_quo, r_rem, r_div, r_a, r_mask;
  logic         r_qneg, r_dz, r_ovf;
`ifdef V_DIV_REM_EN
  logic         r_rneg, r_rem_sel;
  logic [W-1:0] w_remv;
`endif

  // Operand decode: element mask, signs, magnitudes and special cases.
  always_comb begin
    w_mask  = {W{1'b1}} >> (W6 - i_w);
    w_msb   = w_mask ^ (w_mask >> 1);
    w_a     = i_a & w_mask;
    w_b     = i_b & w_mask;
    w_a_neg = i_signed & (|(w_a & w_msb));
    w_b_neg = i_signed & (|(w_b & w_msb));
    w_abs_a = w_a_neg ? ((-w_a) & w_mask) : w_a;
    w_abs_b = w_b_neg ? ((-w_b) & w_mask) : w_b;
    w_dz    = (w_b == '0);
    w_ovf   = i_signed & (w_a == w_msb) & (w_b == w_mask);
  end

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[W-1]};
    w_diff   = {1'b0, w_rem_sh} - {2'b00, r_div};
    w_nb     = ~w_diff[W+1];
  end

  // Lane state: load left-aligns the dividend so its MSB is always bit W-1.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_a    <= '0;
      r_mask <= '0;
      r_qneg <= 1'b0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (i_load) begin
      r_quo  <= w_abs_a << (W6 - i_w);
      r_rem  <= '0;
      r_div  <= w_abs_b;
      r_a    <= w_a;
      r_mask <= w_mask;
      r_qneg <= w_a_neg ^ w_b_neg;
      r_dz   <= w_dz;
      r_ovf  <= w_ovf;
    end else if (i_step) begin
      r_rem  <= w_nb ? w_diff[W-1:0] : w_rem_sh[W-1:0];
      r_quo  <= {r_quo[W-2:0], w_nb};
    end
  end

  // Quotient fixups: divide-by-zero, signed overflow, then sign.
  always_comb begin
    w_qmag = r_quo & r_mask;
    if (r_dz)        w_quo = r_mask;
    else if (r_ovf)  w_quo = r_a;
    else if (r_qneg) w_quo = (-w_qmag) & r_mask;
    else             w_quo = w_qmag;
  end

`ifdef V_DIV_REM_EN
  // Remainder sign and operation select latched with the operands.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rneg    <= 1'b0;
      r_rem_sel <= 1'b0;
    end else if (i_load) begin
      r_rneg    <= w_a_neg;
      r_rem_sel <= i_rem;
    end
  end

  // Remainder fixups and quotient/remainder output select.
  always_comb begin
    if (r_dz)        w_remv = r_a;
    else if (r_ovf)  w_remv = '0;
    else if (r_rneg) w_remv = (-r_rem) & r_mask;
    else             w_remv = r_rem;
    o_res = r_rem_sel ? w_remv : w_quo;
  end
`else
  assign o_res = w_quo;
`endif

endmodule

// File: rtl/v_div.sv
// v_div: iterative SIMD restoring divider (4x8b, 2x16b or 1x32b lanes).
// Start/ready/done handshake; one quotient bit per lane per cycle.
// Optional feature macro: V_DIV_REM_EN enables vremu/vrem; when undefined
// those codes are treated as illegal requests.
module v_div
  import v_div_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        is_div,
  input  logic [31:0] op_A,
  input  logic [31:0] op_B,
  input  logic [1:0]  sew,
  input  logic [5:0]  op_instr,
  output logic        ready,
  output logic        done,
  output logic [31:0] result
);

  v_div_state_e r_state, w_next;
  logic [4:0]   r_cnt;
  logic [1:0]   r_sew;
  logic         r_ill, r_done;
  logic [31:0]  r_result;

  logic         w_accept, w_ill, w_legal_op, w_signed;
  logic [5:0]   w_w, w_w1;
  logic [31:0]  w_res0, w_packed;
  logic [15:0]  w_res1, w_a1, w_b1;
  logic [7:0]   w_res2, w_res3;
`ifdef V_DIV_REM_EN
  logic         w_rem;
`endif

  // Request decode; lane operands are only meaningful on the accept cycle.
  always_comb begin
`ifdef V_DIV_REM_EN
    w_legal_op = (op_instr == VDIVU) | (op_instr == VDIV) |
                 (op_instr == VREMU) | (op_instr == VREM);
    w_signed   = (op_instr == VDIV) | (op_instr == VREM);
    w_rem      = (op_instr == VREMU) | (op_instr == VREM);
`else
    w_legal_op = (op_instr == VDIVU) | (op_instr == VDIV);
    w_signed   = (op_instr == VDIV);
`endif
    w_ill    = (sew == SEW_ILL) | ~w_legal_op;
    w_accept = (r_state == IDLE) & is_div;
    w_w      = sew_bits(sew);
    w_w1     = (sew == SEW_8) ? 6'd8 : 6'd16;
    w_a1     = (sew == SEW_8) ? {8'h00, op_A[15:8]} : op_A[31:16];
    w_b1     = (sew == SEW_8) ? {8'h00, op_B[15:8]} : op_B[31:16];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: illegal requests skip straight to FINISH.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (is_div) w_next = w_ill ? FINISH : DIV;
      DIV:     if (r_cnt == 5'd0) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Step counter and request attributes latched on accept.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= 5'd0;
      r_sew <= 2'b00;
      r_ill <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= 5'(w_w - 6'd1);
      r_sew <= sew;
      r_ill <= w_ill;
    end else if (r_state == DIV) begin
      r_cnt <= r_cnt - 5'd1;
    end
  end

  v_div_lane #(.W(32)) u_lane0 (
    .clk(clk), .nrst(nrst), .i_load(w_accept), .i_step(r_state == DIV),
    .i_signed(w_signed), .i_w(w_w),
`ifdef V_DIV_REM_EN
    .i_rem(w_rem),
`endif
    .i_a(op_A), .i_b(op_B), .o_res(w_res0)
  );

  v_div_lane #(.W(16)) u_lane1 (
    .clk(clk), .nrst(nrst), .i_load(w_accept), .i_step(r_state == DIV),
    .i_signed(w_signed), .i_w(w_w1),
`ifdef V_DIV_REM_EN
    .i_rem(w_rem),
`endif
    .i_a(w_a1), .i_b(w_b1), .o_res(w_res1)
  );

  v_div_lane #(.W(8)) u_lane2 (
    .clk(clk), .nrst(nrst), .i_load(w_accept), .i_step(r_state == DIV),
    .i_signed(w_signed), .i_w(6'd8),
`ifdef V_DIV_REM_EN
    .i_rem(w_rem),
`endif
    .i_a(op_A[23:16]), .i_b(op_B[23:16]), .o_res(w_res2)
  );

  v_div_lane #(.W(8)) u_lane3 (
    .clk(clk), .nrst(nrst), .i_load(w_accept), .i_step(r_state == DIV),
    .i_signed(w_signed), .i_w(6'd8),
`ifdef V_DIV_REM_EN
    .i_rem(w_rem),
`endif
    .i_a(op_A[31:24]), .i_b(op_B[31:24]), .o_res(w_res3)
  );

  // Pack lane results according to the latched element width.
  always_comb begin
    case (r_sew)
      SEW_32:  w_packed = w_res0;
      SEW_16:  w_packed = {w_res1, w_res0[15:0]};
      default: w_packed = {w_res3, w_res2, w_res1[7:0], w_res0[7:0]};
    endcase
  end

  // Result register and done pulse, both updated in FINISH.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= (r_state == FINISH);
      if (r_state == FINISH) r_result <= r_ill ? 32'h0 : w_packed;
    end
  end

  assign ready  = (r_state == IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule
